uart_modport: RTL and testbench

UART_MODPORT -- requirements
Module: uart_modport

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_rx.sv | 85 ++++++++
 rtl/uart_modport.sv | 104 ++++++++++
 tb/tb_uart_modport.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the loopback UART: TX/RX state encodings,
// frame data width and the default bit period.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: samples the line mid-bit, rejects short start glitches and
// drops frames whose stop bit is sampled low.
module uart_rx import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid
);

  localparam int unsigned CntW = $clog2(2 * CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] HalfCnt   = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] SampleCnt = CntW'(CLKS_PER_BIT - 1);
  // Completion lands on the last cycle of the transmitted stop bit, so the
  // pulse always follows the transmitter dropping busy.
  localparam logic [CntW-1:0] DoneCnt   = CntW'(2 * CLKS_PER_BIT - 2 - CLKS_PER_BIT / 2);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(DATA_BITS - 1);

  rx_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 stop_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RxIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      stop_ok_q <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          cnt_q <= '0;
          if (!rx_line) state_q <= RxStart;
        end
        RxStart: begin
          if (cnt_q == HalfCnt) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_line ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == SampleCnt) begin
            cnt_q   <= '0;
            shift_q <= {rx_line, shift_q[DATA_BITS-1:1]};
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= RxStop;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == DoneCnt) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (stop_ok_q) begin
              rx_data  <= shift_q;
              rx_valid <= 1'b1;
            end
          end else begin
            if (cnt_q == SampleCnt) stop_ok_q <= rx_line;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_modport.sv
// UART transmitter with its line looped back into an on-chip receiver.
// The start level is driven combinationally in the cycle tx_start is accepted.
module uart_modport import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 serial_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TxIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        TxIdle: begin
          if (tx_start) begin
            shift_q <= tx_data;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= TxStart;
          end
        end
        TxStart: begin
          if (cnt_q == CntMax) begin
            cnt_q   <= '0;
            state_q <= TxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TxData: begin
          if (cnt_q == CntMax) begin
            cnt_q   <= '0;
            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= TxStop;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TxStop: begin
          if (cnt_q == CntMax) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= TxIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= TxIdle;
      endcase
    end
  end

  always_comb begin
    serial_line = 1'b1;
    unique case (state_q)
      TxIdle:  serial_line = ~(tx_start & rst_n);
      TxStart: serial_line = 1'b0;
      TxData:  serial_line = shift_q[0];
      TxStop:  serial_line = 1'b1;
      default: serial_line = 1'b1;
    endcase
  end

  assign tx_busy = busy_q;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_line (serial_line),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

endmodule

// File: tb/tb_uart_modport.sv
// Scoreboard bench for uart_modport: a frame-offset model predicts the line
// and busy every cycle and queues each accepted byte for the receive monitor.
module tb_uart_modport;

  localparam int CB       = 8;
  localparam int FrameLen = 10 * CB;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_busy;
  logic       serial_line;
  logic [7:0] rx_data;
  logic       rx_valid;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         off      = -1;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] last_rx  = 8'h00;

  uart_modport #(
    .CLKS_PER_BIT(CB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .serial_line(serial_line),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level o cycles after the accept cycle of byte b.
  function automatic logic exp_line(input int o, input logic [7:0] b);
    if (o < 0) return 1'b1;
    if (o <= CB) return 1'b0;
    if (o <= 9 * CB) return b[(o - CB - 1) / CB];
    return 1'b1;
  endfunction

  // Monitor: reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      off = -1;
      exp_q.delete();
      last_rx = 8'h00;
      chk("rst_line", int'(serial_line), 1);
      chk("rst_busy", int'(tx_busy), 0);
      chk("rst_valid", int'(rx_valid), 0);
      chk("rst_data", int'(rx_data), 0);
    end else begin
      if (off == FrameLen + 1) off = -1;
      if (off < 0 && tx_start) begin
        off = 0;
        cur_byte = tx_data;
        exp_q.push_back(tx_data);
      end
      chk("line", int'(serial_line), int'(exp_line(off, cur_byte)));
      chk("busy", int'(tx_busy), int'(off >= 1));
      if (rx_valid) begin
        chk("valid_while_busy", int'(tx_busy), 0);
        chk("rx_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) last_rx = exp_q.pop_front();
      end
      chk("rx_data", int'(rx_data), int'(last_rx));
      if (off >= 0) off++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tx_busy && n < 20 * CB);
    chk("idle_timeout", int'(tx_busy), 0);
  endtask

  task automatic send(input logic [7:0] b);
    wait_idle();
    tx_start = 1'b1;
    tx_data  = b;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] b);
    tx_start = 1'b1;
    tx_data  = b;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || off >= 0) && n < 30 * CB) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(100);
    chk("idle_line", int'(serial_line), 1);
    chk("idle_data", int'(rx_data), 0);

    send(8'hA5);
    drain();

    send(8'h00);
    send(8'hFF);
    drain();

    send(8'h5A);
    cycles(4 * CB);
    pulse(8'h3C);
    drain();
    cycles(2 * FrameLen);

    send(8'hC3);
    cycles(3 * CB);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(tx_busy), 0);
    chk("async_rst_line", int'(serial_line), 1);
    cycles(3);
    rst_n = 1'b1;
    cycles(2 * FrameLen);
    send(8'h81);
    drain();

    for (int i = 0; i < 25; i++) begin
      cycles($urandom_range(0, 2 * CB));
      send(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) begin
        cycles($urandom_range(1, 8 * CB));
        pulse(8'($urandom_range(0, 255)));
      end
    end
    drain();
    cycles(2 * CB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
